// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator request/response port.
// Used by calc_alu and calc_port_responder. The responder's optional parity
// output is enabled by defining CALC_RESP_PARITY_EN; this package is the same
// in both builds.
package calc_pkg;

   localparam int CALC_CMD_WIDTH  = 4;
   localparam int CALC_DATA_WIDTH = 32;
   localparam int CALC_TAG_WIDTH  = 2;

   // One slot per tag value, so the slot table and the tag space match.
   localparam int CALC_SLOTS      = 4;

   // The countdown field is wide enough for latencies up to 257 cycles.
   localparam int CALC_CNT_WIDTH  = 8;

   // The age field ranks the live slots from youngest (0) to oldest
   // (CALC_SLOTS-1), so it only needs to count up to the table depth.
   localparam int CALC_AGE_WIDTH  = $clog2(CALC_SLOTS);

   typedef enum logic [CALC_CMD_WIDTH-1:0] {
      NOP = 4'd0,
      ADD = 4'd1,
      SUB = 4'd2,
      SHL = 4'd5,
      SHR = 4'd6
   } calc_cmd_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      OK   = 2'd1,
      OVF  = 2'd2,
      INV  = 2'd3
   } calc_resp_e;

   // A request that has been accepted and is waiting for its response.
   typedef struct packed {
      logic                       valid;
      logic [CALC_DATA_WIDTH-1:0] result;
      calc_resp_e                 resp;
      logic [CALC_TAG_WIDTH-1:0]  tag;
      logic [CALC_CNT_WIDTH-1:0]  countdown;
      logic [CALC_AGE_WIDTH-1:0]  age;
   } calc_slot_t;

   // Shift commands take the long latency path; everything else, including
   // invalid commands, takes the short one.
   function automatic logic is_shift(input logic [CALC_CMD_WIDTH-1:0] cmd);
      return (cmd == SHL) || (cmd == SHR);
   endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic for the calculator responder.
// Works on unsigned operands. Add carry-out and subtract borrow are both
// reported as OVF with a zeroed result. The shift amount is taken from the low
// bits of op2. Any unknown command returns INV.
module calc_alu
   import calc_pkg::*;
(
   input  logic [CALC_CMD_WIDTH-1:0]  cmd,
   input  logic [CALC_DATA_WIDTH-1:0] op1,
   input  logic [CALC_DATA_WIDTH-1:0] op2,
   output calc_resp_e                 resp,
   output logic [CALC_DATA_WIDTH-1:0] data
);

   localparam int SHAMT_W = $clog2(CALC_DATA_WIDTH);

   logic [CALC_DATA_WIDTH:0] sum_ext;
   logic [SHAMT_W-1:0]       shamt;

   assign sum_ext = {1'b0, op1} + {1'b0, op2};
   assign shamt   = op2[SHAMT_W-1:0];

   // Decode the command and produce the response code and the result.
   always_comb begin
      resp = INV;
      data = '0;
      case (cmd)
         ADD: begin
            if (sum_ext[CALC_DATA_WIDTH]) begin
               resp = OVF;
            end else begin
               resp = OK;
               data = sum_ext[CALC_DATA_WIDTH-1:0];
            end
         end
         SUB: begin
            if (op2 > op1) begin
               resp = OVF;
            end else begin
               resp = OK;
               data = op1 - op2;
            end
         end
         SHL: begin
            resp = OK;
            data = op1 << shamt;
         end
         SHR: begin
            resp = OK;
            data = op1 >> shamt;
         end
         default: begin
            resp = INV;
            data = '0;
         end
      endcase
   end

endmodule

// File: rtl/calc_port_responder.sv
// Behavioural responder for a single calc request/response port.
// A request is captured over two cycles: the command cycle carries op1, and
// the next cycle carries op2. The request is then parked in a slot and counts
// down its command-dependent latency. Each cycle the oldest ready slot is
// presented on out_* and released, so responses may complete out of order.
// Define CALC_RESP_PARITY_EN to add the out_parity output.
module calc_port_responder
   import calc_pkg::*;
#(
   parameter int ADD_LAT = 3,
   parameter int SHF_LAT = 5,
   parameter int SLOTS   = CALC_SLOTS
) (
   input  logic                       PClk,
   input  logic                       Rst,
   input  logic [CALC_CMD_WIDTH-1:0]  req_cmd_in,
   input  logic [CALC_DATA_WIDTH-1:0] req_data_in,
   input  logic [CALC_TAG_WIDTH-1:0]  req_tag_in,
   output logic [1:0]                 out_resp,
   output logic [CALC_DATA_WIDTH-1:0] out_data,
   output logic [CALC_TAG_WIDTH-1:0]  out_tag,
   output logic                       busy,
   output logic                       drop_err
`ifdef CALC_RESP_PARITY_EN
   ,
   output logic                       out_parity
`endif
);

   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   // The slot is written at the end of the op2 cycle, so two cycles of the
   // total latency are already used when the countdown starts.
   localparam logic [CALC_CNT_WIDTH-1:0] ADD_CNT = CALC_CNT_WIDTH'(ADD_LAT - 2);
   localparam logic [CALC_CNT_WIDTH-1:0] SHF_CNT = CALC_CNT_WIDTH'(SHF_LAT - 2);

   typedef enum logic {
      IDLE = 1'b0,
      OP2  = 1'b1
   } cap_state_e;

   cap_state_e                 state_q;
   cap_state_e                 state_d;

   logic [CALC_CMD_WIDTH-1:0]  cmd_q;
   logic [CALC_DATA_WIDTH-1:0] op1_q;
   logic [CALC_TAG_WIDTH-1:0]  tag_q;

   calc_resp_e                 alu_resp;
   logic [CALC_DATA_WIDTH-1:0] alu_data;

   calc_slot_t                 slot_q [SLOTS];
   calc_slot_t                 slot_d [SLOTS];

   logic                       free_found;
   logic [IDX_W-1:0]           free_idx;
   logic                       win_found;
   logic [IDX_W-1:0]           win_idx;
   logic [CALC_AGE_WIDTH-1:0]  win_age;
   logic                       alloc;
   logic                       drop;
   logic [CALC_CNT_WIDTH-1:0]  new_cnt;

   // Capture FSM state register; reset discards any half-captured request.
   always_ff @(posedge PClk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A nonzero command in IDLE starts a request. The following cycle always
   // supplies op2 and ignores req_cmd_in.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_cmd_in != '0) begin
               state_d = OP2;
            end
         end
         OP2: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Hold the command-cycle fields until the op2 cycle completes the request.
   always_ff @(posedge PClk or negedge Rst) begin
      if (!Rst) begin
         cmd_q <= '0;
         op1_q <= '0;
         tag_q <= '0;
      end else if ((state_q == IDLE) && (req_cmd_in != '0)) begin
         cmd_q <= req_cmd_in;
         op1_q <= req_data_in;
         tag_q <= req_tag_in;
      end
   end

   // op2 goes straight from the port into the ALU during the op2 cycle.
   calc_alu u_alu (
      .cmd  (cmd_q),
      .op1  (op1_q),
      .op2  (req_data_in),
      .resp (alu_resp),
      .data (alu_data)
   );

   assign alloc   = (state_q == OP2) && free_found;
   assign drop    = (state_q == OP2) && !free_found;
   assign new_cnt = is_shift(cmd_q) ? SHF_CNT : ADD_CNT;

   // Find the lowest-numbered free slot from the registered valid bits. A
   // slot that is responding this cycle still counts as occupied.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!slot_q[i].valid) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Pick the oldest slot whose countdown has expired. Ages are unique among
   // live slots, so the order of this scan does not change the result.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_age   = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (slot_q[i].valid && (slot_q[i].countdown == '0) &&
             (!win_found || (slot_q[i].age > win_age))) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
            win_age   = slot_q[i].age;
         end
      end
   end

   // Advance every slot by one cycle. The winner is released. Other live
   // slots count down and keep their age equal to the number of younger live
   // slots: a new arrival makes everyone one older, and releasing the winner
   // makes everything older than it one younger. A newly accepted request is
   // loaded into the chosen free slot.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         slot_d[i] = slot_q[i];
         if (slot_q[i].valid) begin
            if (win_found && (win_idx == IDX_W'(i))) begin
               slot_d[i].valid = 1'b0;
            end else begin
               if (slot_q[i].countdown != '0) begin
                  slot_d[i].countdown = slot_q[i].countdown - 1'b1;
               end
               if (alloc) begin
                  slot_d[i].age = slot_d[i].age + 1'b1;
               end
               if (win_found && (slot_q[i].age > win_age)) begin
                  slot_d[i].age = slot_d[i].age - 1'b1;
               end
            end
         end
         if (alloc && (free_idx == IDX_W'(i))) begin
            slot_d[i].valid     = 1'b1;
            slot_d[i].result    = alu_data;
            slot_d[i].resp      = alu_resp;
            slot_d[i].tag       = tag_q;
            slot_d[i].countdown = new_cnt;
            slot_d[i].age       = '0;
         end
      end
   end

   // Slot table register; reset throws away in-flight work without replying.
   always_ff @(posedge PClk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   // Sticky flag recording that a request arrived while every slot was full.
   always_ff @(posedge PClk or negedge Rst) begin
      if (!Rst) begin
         drop_err <= 1'b0;
      end else if (drop) begin
         drop_err <= 1'b1;
      end
   end

   // busy reflects any occupied slot, including one responding this cycle.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         busy = busy | slot_q[i].valid;
      end
   end

   // Present the winning slot, which holds registered data, for exactly the
   // one cycle before it is released. Drive all zeros when nothing is ready.
   always_comb begin
      out_resp = '0;
      out_data = '0;
      out_tag  = '0;
      if (win_found) begin
         out_resp = slot_q[win_idx].resp;
         out_data = slot_q[win_idx].result;
         out_tag  = slot_q[win_idx].tag;
      end
   end

`ifdef CALC_RESP_PARITY_EN
   // Even parity over the whole response. It is zero when idle because every
   // field is zero then.
   assign out_parity = ^{out_resp, out_tag, out_data};
`endif

endmodule
